mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 15 +
 rtl/mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port 32-bit to 16-bit SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Byte offset of the upper halfword within a word.
  localparam logic [31:0] HALF_HI = 32'd2;

  typedef struct packed {
    logic        owner;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Round-robin pick between fetch and data ports; ties go to the port that did not win last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = i_req | d_req;
  assign gnt_id    = (i_req && d_req) ? ~last_owner : (d_req ? PORT_DATA : PORT_FETCH);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data word requests onto a 16-bit SRAM controller,
// low halfword first, with round-robin arbitration between the two ports.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_dtw,
  input  logic [15:0] mem_dtr,
  input  logic        mem_done
);

  state_t      state;
  xact_t       cur;
  xact_t       win;
  logic        last_owner;
  logic [15:0] rdata_lo;
  logic        gnt_valid;
  logic        gnt_id;

  // Word alignment drops the byte-lane bits of both addresses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    win       = '0;
    win.owner = gnt_id;
    win.rw    = (gnt_id == PORT_DATA) ? d_rw : 1'b0;
    win.addr  = (gnt_id == PORT_DATA) ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
    win.wdata = d_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      last_owner <= PORT_FETCH;
      rdata_lo   <= '0;
      mem_valid  <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_dtw    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      mem_valid <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          cur       <= win;
          mem_valid <= 1'b1;
          mem_rw    <= win.rw;
          mem_addr  <= win.addr;
          mem_dtw   <= win.wdata[15:0];
          state     <= ISSUE_LO;
        end
        ISSUE_LO: state <= WAIT_LO;
        WAIT_LO: if (mem_done) begin
          if (!cur.rw) rdata_lo <= mem_dtr;
          mem_valid <= 1'b1;
          mem_addr  <= cur.addr + HALF_HI;
          mem_dtw   <= cur.wdata[31:16];
          state     <= ISSUE_HI;
        end
        ISSUE_HI: state <= WAIT_HI;
        WAIT_HI: if (mem_done) begin
          // Ack and read data are registered so they appear together in RESP.
          if (cur.owner == PORT_DATA) begin
            d_ack <= 1'b1;
            if (!cur.rw) d_rdata <= {mem_dtr, rdata_lo};
          end else begin
            i_ack   <= 1'b1;
            i_rdata <= {mem_dtr, rdata_lo};
          end
          state <= RESP;
        end
        RESP: begin
          last_owner <= cur.owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
